// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - washing machine sequencer state encoding and actuator lookup
package wm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREWASH = 3'd1,
    FILL    = 3'd2,
    WASH    = 3'd3,
    RINSE   = 3'd4,
    DRAIN   = 3'd5,
    SPIN    = 3'd6,
    DONE    = 3'd7
  } wm_state_e;

  typedef struct packed {
    logic agitator;
    logic motor;
    logic pump;
    logic speed;
    logic water_fill;
  } wm_act_t;

  function automatic wm_act_t wm_outputs(input wm_state_e s);
    wm_act_t a;
    a = '0;
    case (s)
      PREWASH: begin
        a.water_fill = 1'b1;
        a.agitator   = 1'b1;
        a.motor      = 1'b1;
      end
      FILL:  a.water_fill = 1'b1;
      WASH, RINSE: begin
        a.agitator = 1'b1;
        a.motor    = 1'b1;
      end
      DRAIN: a.pump = 1'b1;
      SPIN: begin
        a.motor = 1'b1;
        a.speed = 1'b1;
        a.pump  = 1'b1;
      end
      default: a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// rtl/wm_phase_timer.sv - loadable down-counter that holds when not enabled
module wm_phase_timer #(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          en,
  output logic          zero
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && cnt_q != '0) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/washing_machine_seq_ctrl.sv
// rtl/washing_machine_seq_ctrl.sv - wash program sequencer with pause, abort and rinse loops
// Optional prewash phase and prewash_req port enabled by WM_PREWASH_EN.
module washing_machine_seq_ctrl
  import wm_pkg::*;
#(
  parameter int TW            = 16,
  parameter int FILL_TICKS    = 8,
  parameter int WASH_TICKS    = 16,
  parameter int RINSE_TICKS   = 12,
  parameter int DRAIN_TICKS   = 6,
  parameter int SPIN_TICKS    = 10,
  parameter int MAX_RINSE     = 3,
  parameter int RW            = 2,
  parameter int PREWASH_TICKS = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          door,
  input  logic          abort,
`ifdef WM_PREWASH_EN
  input  logic          prewash_req,
`endif
  input  logic [RW-1:0] rinse_sel,
  output logic          agitator,
  output logic          motor,
  output logic          pump,
  output logic          speed,
  output logic          water_fill,
  output logic          busy,
  output logic          paused,
  output logic          done,
  output logic [2:0]    phase
);

  localparam logic [RW-1:0] MAX_R = RW'(MAX_RINSE);

  wm_state_e     state_q, state_d;
  logic [RW-1:0] rinse_left_q, rinse_left_d;
  logic          rinse_flag_q, rinse_flag_d;
  logic          abort_q, abort_d;
  logic          pend_q, pend_d;
  logic          tmr_load, tmr_en, tmr_zero;
  logic [TW-1:0] tmr_val;
  logic          active, halt, abort_req, pre_sel;
  wm_act_t       act;

`ifdef WM_PREWASH_EN
  assign pre_sel = prewash_req;
`else
  assign pre_sel = 1'b0;
`endif

  function automatic logic [TW-1:0] ticks_m1(input wm_state_e s);
    case (s)
      PREWASH: ticks_m1 = TW'(PREWASH_TICKS - 1);
      FILL:    ticks_m1 = TW'(FILL_TICKS - 1);
      WASH:    ticks_m1 = TW'(WASH_TICKS - 1);
      RINSE:   ticks_m1 = TW'(RINSE_TICKS - 1);
      DRAIN:   ticks_m1 = TW'(DRAIN_TICKS - 1);
      SPIN:    ticks_m1 = TW'(SPIN_TICKS - 1);
      default: ticks_m1 = '0;
    endcase
  endfunction

  wm_phase_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  assign active    = (state_q != IDLE) && (state_q != DONE);
  assign halt      = active && door;
  assign abort_req = active && abort && !abort_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      rinse_left_q <= '0;
      rinse_flag_q <= 1'b0;
      abort_q      <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rinse_left_q <= rinse_left_d;
      rinse_flag_q <= rinse_flag_d;
      abort_q      <= abort_d;
      pend_q       <= pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rinse_left_d = rinse_left_q;
    rinse_flag_d = rinse_flag_q;
    abort_d      = abort_q;
    pend_d       = pend_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    tmr_en       = 1'b0;
    if (state_q == IDLE) begin
      if (start && !door) begin
        rinse_left_d = (rinse_sel > MAX_R) ? MAX_R : rinse_sel;
        rinse_flag_d = 1'b0;
        abort_d      = 1'b0;
        pend_d       = 1'b0;
        state_d      = pre_sel ? PREWASH : FILL;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (abort_req) begin
      abort_d      = 1'b1;
      rinse_left_d = '0;
      // An abort seen while the door is open waits for the door to close.
      if (halt) pend_d = 1'b1;
      else      state_d = DRAIN;
    end else if (halt) begin
      state_d = state_q;
    end else if (pend_q) begin
      pend_d  = 1'b0;
      state_d = DRAIN;
    end else if (tmr_zero) begin
      case (state_q)
        PREWASH: state_d = FILL;
        FILL:    state_d = rinse_flag_q ? RINSE : WASH;
        WASH:    state_d = DRAIN;
        RINSE: begin
          state_d      = DRAIN;
          rinse_left_d = rinse_left_q - RW'(1);
        end
        DRAIN: begin
          if (abort_q) begin
            state_d = IDLE;
            abort_d = 1'b0;
          end else if (rinse_left_q != '0) begin
            state_d      = FILL;
            rinse_flag_d = 1'b1;
          end else begin
            state_d = SPIN;
          end
        end
        SPIN:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end else begin
      tmr_en = 1'b1;
    end
    if (state_d != state_q || (state_q == DRAIN && abort_req && !halt)) begin
      tmr_load = 1'b1;
      tmr_val  = ticks_m1(state_d);
    end
  end

  always_comb begin
    act        = halt ? '0 : wm_outputs(state_q);
    agitator   = act.agitator;
    motor      = act.motor;
    pump       = act.pump;
    speed      = act.speed;
    water_fill = act.water_fill;
    busy       = (state_q != IDLE);
    paused     = halt;
    done       = (state_q == DONE);
    phase      = state_q;
  end

endmodule
